hbridge_chopper: RTL

//   Peak-current chopper driving the four gates of one H-bridge coil.

---
 rtl/hbridge_if.sv | 28 ++
 rtl/hbridge_chopper.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hbridge_if.sv
// Bundle of the chopper's regulation inputs and gate/status outputs.
// The master side (current table or testbench) drives the setpoint and the
// measured current; the slave side (the chopper) drives the gates and status.
interface hbridge_if #(
    parameter int CUR_W = 13
);
    logic             enable;
    logic             dir;
    logic [CUR_W-1:0] target;
    logic [CUR_W-1:0] current;
    logic             s_l0;
    logic             s_h0;
    logic             s_l1;
    logic             s_h1;
    logic             chop;
    logic             stall;
    logic [1:0]       state;

    modport master (
        output enable, dir, target, current,
        input  s_l0, s_h0, s_l1, s_h1, chop, stall, state
    );

    modport slave (
        input  enable, dir, target, current,
        output s_l0, s_h0, s_l1, s_h1, chop, stall, state
    );
endinterface

// File: rtl/hbridge_chopper.sv
// Peak-current chopper for one H-bridge coil.
// Four states: IDLE (bridge off), DEAD (all-off before driving), ON (driving,
// comparator blanked for the first cycles), OFF (fixed decay time after a
// trip). Gate commands are active-low and registered together with the state,
// so gates never disagree with the reported state. OFF is at least as long as
// the dead-time, which lets a direction change taken at the end of OFF go
// straight to ON without an extra DEAD phase.
module hbridge_chopper #(
    parameter int CUR_W        = 13,
    parameter int DEAD_CYCLES  = 4,
    parameter int BLANK_CYCLES = 8,
    parameter int TOFF_CYCLES  = 64,
    parameter int ON_MAX       = 256
) (
    input  logic      clk,
    input  logic      resetn,
    hbridge_if.slave  bus
);

    // One shared counter serves every state, so it is sized for the largest
    // interval any state has to time.
    localparam int MAX_A = (DEAD_CYCLES > BLANK_CYCLES) ? DEAD_CYCLES : BLANK_CYCLES;
    localparam int MAX_B = (TOFF_CYCLES > ON_MAX) ? TOFF_CYCLES : ON_MAX;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    // DEAD and OFF count from 0 on entry; ON counts from 1 so the counter
    // equals the on-cycle number directly.
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(TOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] ON_LIMIT  = CNT_W'(ON_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Gate vector order: {s_l0, s_h0, s_l1, s_h1}, 0 = transistor on.
    localparam logic [3:0] GATES_OFF = 4'b1111;
    localparam logic [3:0] GATES_POS = 4'b0110;
    localparam logic [3:0] GATES_NEG = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2,
        OFF  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             act_dir_q, act_dir_d;
    logic             stall_q, stall_d;
    logic             chop_q, chop_d;
    logic [3:0]       gates_q, gates_d;

    logic             enable;
    logic             dir;
    logic [CUR_W-1:0] target;
    logic [CUR_W-1:0] current;
    logic             go;
    logic             dir_changed;
    logic             tripped;

    assign enable  = bus.enable;
    assign dir     = bus.dir;
    assign target  = bus.target;
    assign current = bus.current;

    assign go          = enable && !stall_q && (target != '0);
    assign dir_changed = (dir != act_dir_q);
    assign tripped     = (cnt_q >= BLANK_END) && (current >= target);

    // Counter never wraps: it sticks at all-ones if ever left running.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

    // Only ON drives the bridge; the latched direction picks the diagonal.
    function automatic logic [3:0] gates_for(input state_t s, input logic d);
        if (s == ON) begin
            return d ? GATES_NEG : GATES_POS;
        end
        return GATES_OFF;
    endfunction

    // Next-state, counter, direction latch, stall and chop decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        act_dir_d = act_dir_q;
        stall_d   = stall_q && enable;
        chop_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d   = DEAD;
                    act_dir_d = dir;
                end
            end
            DEAD: begin
                if (!go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= DEAD_LAST) begin
                    state_d = ON;
                    cnt_d   = CNT_ONE;
                end
            end
            ON: begin
                if (!go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (dir_changed) begin
                    state_d   = DEAD;
                    cnt_d     = '0;
                    act_dir_d = dir;
                end else if (cnt_q >= ON_LIMIT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    stall_d = 1'b1;
                end else if (tripped) begin
                    state_d = OFF;
                    cnt_d   = '0;
                    chop_d  = 1'b1;
                end
            end
            OFF: begin
                if (!go) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= OFF_LAST) begin
                    state_d   = ON;
                    cnt_d     = CNT_ONE;
                    act_dir_d = dir;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        gates_d = gates_for(state_d, act_dir_d);
    end

    // State, counter and registered gate/status outputs; reset forces all off.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            act_dir_q <= 1'b0;
            stall_q   <= 1'b0;
            chop_q    <= 1'b0;
            gates_q   <= GATES_OFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_dir_q <= act_dir_d;
            stall_q   <= stall_d;
            chop_q    <= chop_d;
            gates_q   <= gates_d;
        end
    end

    assign bus.s_l0  = gates_q[3];
    assign bus.s_h0  = gates_q[2];
    assign bus.s_l1  = gates_q[1];
    assign bus.s_h1  = gates_q[0];
    assign bus.chop  = chop_q;
    assign bus.stall = stall_q;
    assign bus.state = state_q;

endmodule
